// File: rtl/mem_port_arbiter.sv
// Arbiter that shares the single external memory port between instruction fetch and the
// memory stage: one transaction at a time, MEM-first priority, kill filtering and response timeout.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        mem_err,

    output logic        if_stall,
    output logic        mem_stall,

    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;
    typedef enum logic {OWN_IF, OWN_MEM} owner_e;

    state_e         state_q;
    owner_e         owner_q;
    logic [31:0]    hold_addr_q;
    logic           hold_we_q;
    logic [31:0]    hold_wdata_q;
    logic [3:0]     hold_wstrb_q;
    logic [CW-1:0]  cnt_q;
    logic           killed_q;

    logic           if_rvalid_q;
    logic           if_err_q;
    logic [31:0]    if_rdata_q;
    logic           mem_rvalid_q;
    logic           mem_err_q;
    logic [31:0]    mem_rdata_q;

    logic           mem_grant;
    logic           if_grant;
    logic           killed_d;
    logic [CW-1:0]  cnt_d;
    logic           timed_out;

    // Grants are combinational and forced low while reset is asserted so every output reads 0.
    assign mem_grant = reset_n & (state_q == IDLE) & mem_req;
    assign if_grant  = reset_n & (state_q == IDLE) & ~mem_req & if_req & ~if_kill;

    assign killed_d  = killed_q | (if_kill & (owner_q == OWN_IF) & (state_q != IDLE));
    assign cnt_d     = cnt_q + CW'(1);
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

    assign if_gnt     = if_grant;
    assign mem_gnt    = mem_grant;
    assign if_rvalid  = if_rvalid_q;
    assign if_err     = if_err_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rvalid = mem_rvalid_q;
    assign mem_err    = mem_err_q;
    assign mem_rdata  = mem_rdata_q;

    assign if_stall  = reset_n & ((if_req & ~if_grant) |
                                  ((owner_q == OWN_IF) & (state_q != IDLE)));
    assign mem_stall = reset_n & ((mem_req & ~mem_grant) |
                                  ((owner_q == OWN_MEM) & (state_q != IDLE)));

    assign bus_valid = (state_q == ADDR);
    assign bus_addr  = hold_addr_q;
    assign bus_we    = hold_we_q;
    assign bus_wdata = hold_wdata_q;
    assign bus_wstrb = hold_wstrb_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            hold_addr_q  <= '0;
            hold_we_q    <= 1'b0;
            hold_wdata_q <= '0;
            hold_wstrb_q <= '0;
            cnt_q        <= '0;
            killed_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            if_err_q     <= 1'b0;
            if_rdata_q   <= '0;
            mem_rvalid_q <= 1'b0;
            mem_err_q    <= 1'b0;
            mem_rdata_q  <= '0;
        end else begin
            if_rvalid_q  <= 1'b0;
            if_err_q     <= 1'b0;
            mem_rvalid_q <= 1'b0;
            mem_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    killed_q <= 1'b0;
                    if (mem_grant) begin
                        state_q      <= ADDR;
                        owner_q      <= OWN_MEM;
                        hold_addr_q  <= mem_addr;
                        hold_we_q    <= mem_we;
                        hold_wdata_q <= mem_wdata;
                        hold_wstrb_q <= mem_wstrb;
                    end else if (if_grant) begin
                        state_q      <= ADDR;
                        owner_q      <= OWN_IF;
                        hold_addr_q  <= if_addr;
                        hold_we_q    <= 1'b0;
                        hold_wdata_q <= '0;
                        hold_wstrb_q <= '0;
                    end
                end
                ADDR: begin
                    killed_q <= killed_d;
                    if (bus_ready) begin
                        state_q <= RESP;
                        cnt_q   <= '0;
                    end
                end
                RESP: begin
                    // A killed fetch still drains the bus, but its response never reaches the pipeline.
                    if (bus_rvalid) begin
                        state_q  <= IDLE;
                        killed_q <= 1'b0;
                        if (owner_q == OWN_MEM) begin
                            mem_rvalid_q <= 1'b1;
                            mem_rdata_q  <= hold_we_q ? 32'h0 : bus_rdata;
                        end else if (!killed_d) begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= hold_we_q ? 32'h0 : bus_rdata;
                        end
                    end else if (timed_out) begin
                        state_q  <= IDLE;
                        killed_q <= 1'b0;
                        if (owner_q == OWN_MEM) begin
                            mem_err_q <= 1'b1;
                        end else if (!killed_d) begin
                            if_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q    <= cnt_d;
                        killed_q <= killed_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a randomized phase checked
// against a transaction-level model (one outstanding request, response-time arithmetic).
module tb_mem_port_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, if_kill;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid, mem_err;
    logic [31:0] mem_rdata;
    logic        if_stall, mem_stall;
    logic        bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err),
        .if_stall(if_stall), .mem_stall(mem_stall),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_we(bus_we),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleEdge();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rd);
        bus_ready  = rdy;
        bus_rvalid = rv;
        bus_rdata  = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Random-phase model state
    bit          busy, curMem, hsDone, never, respNow;
    bit          pendValid, pendErr, pendMem, dropMem, dropIf;
    bit          eMemGnt, eIfGnt;
    logic [31:0] eAddr, eWdata, pendData, lastIfData, lastMemData;
    logic        eWe;
    logic [3:0]  eWstrb;
    int          respCyc, deadline;

    initial begin
        reset_n = 1'b0;
        if_req = 0; if_kill = 0; if_addr = 0;
        mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
        applyStimulus(0, 0, 0);
        nextCycle();
        nextCycle();
        sampleEdge();
        checkOutput("rst_bus_valid", bus_valid, 0);
        checkOutput("rst_if_rdata", if_rdata, 0);
        checkOutput("rst_mem_rdata", mem_rdata, 0);
        checkOutput("rst_if_stall", if_stall, 0);
        checkOutput("rst_bus_addr", bus_addr, 0);
        nextCycle();
        reset_n = 1'b1;

        $display("[TB] lone fetch");
        nextCycle();
        if_req = 1; if_addr = 32'h100;
        sampleEdge();
        checkOutput("lf_if_gnt", if_gnt, 1);
        checkOutput("lf_mem_gnt", mem_gnt, 0);
        checkOutput("lf_bus_valid_T", bus_valid, 0);
        nextCycle();
        if_req = 0; applyStimulus(1, 0, 0);
        sampleEdge();
        checkOutput("lf_bus_valid", bus_valid, 1);
        checkOutput("lf_bus_addr", bus_addr, 32'h100);
        checkOutput("lf_bus_we", bus_we, 0);
        checkOutput("lf_if_stall1", if_stall, 1);
        nextCycle();
        applyStimulus(0, 1, 32'h00500093);
        sampleEdge();
        checkOutput("lf_if_stall2", if_stall, 1);
        checkOutput("lf_bus_valid_drop", bus_valid, 0);
        checkOutput("lf_if_rvalid_early", if_rvalid, 0);
        nextCycle();
        applyStimulus(0, 0, 0);
        sampleEdge();
        checkOutput("lf_if_rvalid", if_rvalid, 1);
        checkOutput("lf_if_rdata", if_rdata, 32'h00500093);
        checkOutput("lf_if_stall3", if_stall, 0);
        nextCycle();
        sampleEdge();
        checkOutput("lf_if_rvalid_pulse", if_rvalid, 0);
        checkOutput("lf_if_rdata_hold", if_rdata, 32'h00500093);

        $display("[TB] simultaneous requests");
        nextCycle();
        mem_req = 1; mem_we = 1; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF; mem_wstrb = 4'hF;
        if_req = 1; if_addr = 32'h200;
        sampleEdge();
        checkOutput("sim_mem_gnt", mem_gnt, 1);
        checkOutput("sim_if_gnt", if_gnt, 0);
        checkOutput("sim_if_stall", if_stall, 1);
        checkOutput("sim_mem_stall", mem_stall, 0);
        nextCycle();
        mem_req = 0; applyStimulus(1, 0, 0);
        sampleEdge();
        checkOutput("sim_bus_addr", bus_addr, 32'h2000);
        checkOutput("sim_bus_we", bus_we, 1);
        checkOutput("sim_bus_wdata", bus_wdata, 32'hDEADBEEF);
        checkOutput("sim_bus_wstrb", bus_wstrb, 4'hF);
        checkOutput("sim_if_gnt_busy", if_gnt, 0);
        checkOutput("sim_mem_stall_busy", mem_stall, 1);
        nextCycle();
        applyStimulus(0, 1, 32'h12345678);
        sampleEdge();
        checkOutput("sim_if_stall_resp", if_stall, 1);
        nextCycle();
        applyStimulus(0, 0, 0);
        sampleEdge();
        checkOutput("sim_mem_rvalid", mem_rvalid, 1);
        checkOutput("sim_mem_rdata_wr0", mem_rdata, 0);
        checkOutput("sim_if_gnt_next", if_gnt, 1);
        checkOutput("sim_mem_stall_done", mem_stall, 0);
        nextCycle();
        if_req = 0; applyStimulus(1, 0, 0);
        sampleEdge();
        checkOutput("sim_fetch_addr", bus_addr, 32'h200);
        nextCycle();
        applyStimulus(0, 1, 32'hCAFEF00D);
        sampleEdge();
        nextCycle();
        applyStimulus(0, 0, 0);
        sampleEdge();
        checkOutput("sim_if_rvalid", if_rvalid, 1);
        checkOutput("sim_if_rdata", if_rdata, 32'hCAFEF00D);

        $display("[TB] kill mid-fetch");
        nextCycle();
        if_req = 1; if_addr = 32'h300;
        sampleEdge();
        checkOutput("kill_if_gnt", if_gnt, 1);
        nextCycle();
        if_req = 0; applyStimulus(1, 0, 0);
        sampleEdge();
        nextCycle();
        applyStimulus(0, 0, 0); if_kill = 1;
        sampleEdge();
        checkOutput("kill_if_stall", if_stall, 1);
        nextCycle();
        if_kill = 0; applyStimulus(0, 1, 32'hBADBAD00);
        sampleEdge();
        nextCycle();
        applyStimulus(0, 0, 0); if_req = 1; if_addr = 32'h304;
        sampleEdge();
        checkOutput("kill_no_rvalid", if_rvalid, 0);
        checkOutput("kill_no_err", if_err, 0);
        checkOutput("kill_rdata_hold", if_rdata, 32'hCAFEF00D);
        checkOutput("kill_regrant", if_gnt, 1);
        nextCycle();
        if_req = 0; applyStimulus(1, 0, 0);
        sampleEdge();
        checkOutput("kill_next_addr", bus_addr, 32'h304);
        nextCycle();
        applyStimulus(0, 1, 32'h0FF00FF0);
        sampleEdge();
        nextCycle();
        applyStimulus(0, 0, 0);
        sampleEdge();
        checkOutput("kill_next_rvalid", if_rvalid, 1);
        checkOutput("kill_next_rdata", if_rdata, 32'h0FF00FF0);

        $display("[TB] timeout");
        nextCycle();
        mem_req = 1; mem_we = 0; mem_addr = 32'h400; mem_wdata = 0; mem_wstrb = 0;
        sampleEdge();
        checkOutput("to_mem_gnt", mem_gnt, 1);
        nextCycle();
        mem_req = 0; applyStimulus(1, 0, 0);
        sampleEdge();
        checkOutput("to_bus_addr", bus_addr, 32'h400);
        nextCycle();
        applyStimulus(0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            sampleEdge();
            checkOutput("to_err_early", mem_err, 0);
            checkOutput("to_stall", mem_stall, 1);
            nextCycle();
        end
        applyStimulus(0, 1, 32'hDEAD0001);
        sampleEdge();
        checkOutput("to_mem_err", mem_err, 1);
        checkOutput("to_no_rvalid", mem_rvalid, 0);
        checkOutput("to_stall_done", mem_stall, 0);
        nextCycle();
        applyStimulus(0, 0, 0);
        sampleEdge();
        checkOutput("to_err_single", mem_err, 0);
        checkOutput("to_late_ignored", mem_rvalid, 0);
        checkOutput("to_idle", bus_valid, 0);
        checkOutput("to_rdata_hold", mem_rdata, 0);

        $display("[TB] bus backpressure");
        nextCycle();
        mem_req = 1; mem_we = 0; mem_addr = 32'h500;
        sampleEdge();
        checkOutput("bp_mem_gnt", mem_gnt, 1);
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            mem_req = 0; applyStimulus(0, 0, 0); if_kill = (k == 2);
            sampleEdge();
            checkOutput("bp_valid", bus_valid, 1);
            checkOutput("bp_addr", bus_addr, 32'h500);
            checkOutput("bp_we", bus_we, 0);
        end
        nextCycle();
        if_kill = 0; applyStimulus(1, 0, 0);
        sampleEdge();
        checkOutput("bp_valid_hs", bus_valid, 1);
        nextCycle();
        applyStimulus(0, 1, 32'h55AA55AA);
        sampleEdge();
        checkOutput("bp_valid_drop", bus_valid, 0);
        nextCycle();
        applyStimulus(0, 0, 0);
        sampleEdge();
        checkOutput("bp_mem_rvalid", mem_rvalid, 1);
        checkOutput("bp_mem_rdata", mem_rdata, 32'h55AA55AA);

        $display("[TB] reset mid-transaction");
        nextCycle();
        if_req = 1; if_addr = 32'h600;
        sampleEdge();
        checkOutput("rm_if_gnt", if_gnt, 1);
        nextCycle();
        if_req = 0; mem_req = 1; reset_n = 1'b0;
        sampleEdge();
        checkOutput("rm_bus_valid", bus_valid, 0);
        checkOutput("rm_mem_gnt", mem_gnt, 0);
        checkOutput("rm_mem_stall", mem_stall, 0);
        checkOutput("rm_if_stall", if_stall, 0);
        checkOutput("rm_bus_addr", bus_addr, 0);
        checkOutput("rm_if_rdata", if_rdata, 0);
        checkOutput("rm_mem_rdata", mem_rdata, 0);
        nextCycle();
        reset_n = 1'b1; mem_req = 0; if_req = 1; if_addr = 32'h700;
        sampleEdge();
        checkOutput("rm_fresh_gnt", if_gnt, 1);
        checkOutput("rm_no_stale", if_rvalid, 0);
        nextCycle();
        if_req = 0; applyStimulus(1, 0, 0);
        sampleEdge();
        checkOutput("rm_bus_addr_new", bus_addr, 32'h700);
        nextCycle();
        applyStimulus(0, 1, 32'h77777777);
        sampleEdge();
        nextCycle();
        applyStimulus(0, 0, 0);
        sampleEdge();
        checkOutput("rm_if_rvalid", if_rvalid, 1);
        checkOutput("rm_if_rdata", if_rdata, 32'h77777777);

        $display("[TB] randomized traffic");
        busy = 0; hsDone = 0; never = 0; pendValid = 0; pendErr = 0; pendMem = 0;
        dropMem = 0; dropIf = 0; curMem = 0; respCyc = 0; deadline = 0;
        eAddr = 0; eWdata = 0; eWe = 0; eWstrb = 0; pendData = 0;
        lastIfData = 32'h77777777; lastMemData = 32'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            nextCycle();
            if (dropMem) mem_req = 0;
            if (dropIf) if_req = 0;
            dropMem = 0; dropIf = 0;
            if (!mem_req && $urandom_range(3) == 0) begin
                mem_req = 1; mem_we = 1'($urandom_range(1)); mem_addr = $urandom;
                mem_wdata = $urandom; mem_wstrb = 4'($urandom_range(15));
            end
            if (!if_req && $urandom_range(2) == 0) begin
                if_req = 1; if_addr = $urandom;
            end
            respNow = busy && hsDone && !never && (cyc == respCyc);
            applyStimulus(1'($urandom_range(1)),
                          respNow ? 1'b1 : ((!(busy && hsDone)) && ($urandom_range(7) == 0)),
                          $urandom);
            sampleEdge();

            eMemGnt = !busy && mem_req;
            eIfGnt  = !busy && if_req && !mem_req;
            checkOutput("rnd_mem_gnt", mem_gnt, eMemGnt);
            checkOutput("rnd_if_gnt", if_gnt, eIfGnt);
            checkOutput("rnd_if_stall", if_stall, (if_req && !eIfGnt) || (busy && !curMem));
            checkOutput("rnd_mem_stall", mem_stall, (mem_req && !eMemGnt) || (busy && curMem));
            checkOutput("rnd_bus_valid", bus_valid, busy && !hsDone);
            checkOutput("rnd_if_rvalid", if_rvalid, pendValid && !pendMem);
            checkOutput("rnd_mem_rvalid", mem_rvalid, pendValid && pendMem);
            checkOutput("rnd_if_err", if_err, pendErr && !pendMem);
            checkOutput("rnd_mem_err", mem_err, pendErr && pendMem);
            if (pendValid && pendMem) lastMemData = pendData;
            if (pendValid && !pendMem) lastIfData = pendData;
            checkOutput("rnd_if_rdata", if_rdata, lastIfData);
            checkOutput("rnd_mem_rdata", mem_rdata, lastMemData);
            if (busy && !hsDone) begin
                checkOutput("rnd_bus_addr", bus_addr, eAddr);
                checkOutput("rnd_bus_we", bus_we, eWe);
                checkOutput("rnd_bus_wstrb", bus_wstrb, eWstrb);
                if (eWe) checkOutput("rnd_bus_wdata", bus_wdata, eWdata);
            end

            pendValid = 0; pendErr = 0;
            if (busy && !hsDone && bus_ready) begin
                hsDone   = 1;
                respCyc  = cyc + 1 + int'($urandom_range(3));
                never    = ($urandom_range(5) == 0);
                deadline = cyc + 1 + int'(TO);
            end else if (busy && hsDone) begin
                if (respNow) begin
                    busy = 0; pendValid = 1; pendMem = curMem;
                    pendData = eWe ? 32'h0 : bus_rdata;
                end else if (cyc == deadline) begin
                    busy = 0; pendErr = 1; pendMem = curMem;
                end
            end
            if (eMemGnt) begin
                busy = 1; hsDone = 0; curMem = 1; dropMem = 1;
                eAddr = mem_addr; eWe = mem_we; eWdata = mem_wdata; eWstrb = mem_wstrb;
            end else if (eIfGnt) begin
                busy = 1; hsDone = 0; curMem = 0; dropIf = 1;
                eAddr = if_addr; eWe = 0; eWdata = 0; eWstrb = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
